pc_fetch_sequencer: RTL and testbench

Program-counter sequencer for the MIPS fetch stage. Owns the PC register, drives the existing 32-bit incrementer as the sequential next-PC source, and runs the instruction-memory request/acknowledge handshake. Arbitrates PC updates among increment, branch/jump redirect, exception vector and halt, and delivers each fetched word's PC to decode. Sits between the instruction memory and the IF/ID pipeline register.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/Incrementer_32bit.sv | 15 +
 rtl/pc_fetch_sequencer.sv | 164 ++++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared types and default constants for the MIPS fetch stage.
// Revision : 1.0  initial release
// ============================================================================
package mips_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_STALL = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_t;

  // Default word address loaded on reset
  localparam logic [31:0] c_RESET_PC   = 32'h0000_0000;
  // Default word address loaded on exception
  localparam logic [31:0] c_EXC_VECTOR = 32'h0000_0020;

endpackage
`default_nettype wire

// File: rtl/Incrementer_32bit.sv
`default_nettype none
// ============================================================================
// Module   : Incrementer_32bit
// Brief    : 32-bit +1 incrementer, modular (wraps to zero, no carry out).
// Revision : 1.0  initial release
// ============================================================================
module Incrementer_32bit (
  input  logic [31:0] i_a,
  output logic [31:0] o_sum
);

  assign o_sum = i_a + 32'd1;

endmodule
`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_sequencer
// Brief    : PC register, next-PC arbitration and instruction-memory
//            request/acknowledge handshake for the fetch stage.
// Revision : 1.0  initial release
// ============================================================================
module pc_fetch_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = c_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = c_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        exc,
  input  logic        halt,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus1,
  output logic        halted
);

  fetch_state_t r_state, w_state_nxt;

  logic [31:0] r_pc, w_pc_nxt;
  logic        r_req, w_req_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic        r_if_valid, w_if_valid_nxt;
  logic [31:0] r_if_pc, w_if_pc_nxt;
  logic [31:0] r_if_pc_plus1, w_if_pc_plus1_nxt;
  // Pending redirect: r_pend_exc marks that the held target is the exception
  // vector, so a later branch redirect must not replace it.
  logic        r_pend_valid, w_pend_valid_nxt;
  logic        r_pend_exc, w_pend_exc_nxt;
  logic [31:0] r_pend_target, w_pend_target_nxt;

  logic [31:0] w_addr_plus1;
  logic [31:0] w_fetch_tgt;

  // One incrementer serves both the sequential next-PC and the link value,
  // since both are derived from the address currently being fetched.
  Incrementer_32bit u_inc (
    .i_a   (r_addr),
    .o_sum (w_addr_plus1)
  );

  // Next PC after an acknowledged fetch: exc > pending exc > redirect > pending redirect > +1
  always_comb begin
    w_fetch_tgt = w_addr_plus1;
    if (exc)                              w_fetch_tgt = EXC_VECTOR;
    else if (r_pend_valid && r_pend_exc)  w_fetch_tgt = r_pend_target;
    else if (redirect_valid)              w_fetch_tgt = redirect_target;
    else if (r_pend_valid)                w_fetch_tgt = r_pend_target;
  end

  // Next-state and next-output decode for the sequencer
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_req_nxt         = r_req;
    w_addr_nxt        = r_addr;
    w_if_valid_nxt    = 1'b0;
    w_if_pc_nxt       = r_if_pc;
    w_if_pc_plus1_nxt = r_if_pc_plus1;
    w_pend_valid_nxt  = r_pend_valid;
    w_pend_exc_nxt    = r_pend_exc;
    w_pend_target_nxt = r_pend_target;

    case (r_state)
      S_IDLE, S_STALL: begin
        // No request outstanding, so redirects load the PC directly
        if (exc)                 w_pc_nxt = EXC_VECTOR;
        else if (redirect_valid) w_pc_nxt = redirect_target;
        if ((r_state == S_IDLE) || !stall) begin
          w_state_nxt = S_FETCH;
          w_req_nxt   = 1'b1;
          w_addr_nxt  = w_pc_nxt;
        end
      end

      S_FETCH: begin
        if (imem_ack) begin
          w_if_pc_nxt       = r_addr;
          w_if_pc_plus1_nxt = w_addr_plus1;
          w_if_valid_nxt    = !(exc || redirect_valid || r_pend_valid);
          w_pend_valid_nxt  = 1'b0;
          w_pend_exc_nxt    = 1'b0;
          w_pc_nxt          = w_fetch_tgt;
          if (halt && !exc) begin
            w_state_nxt = S_HALT;
            w_req_nxt   = 1'b0;
          end else if (stall) begin
            w_state_nxt = S_STALL;
            w_req_nxt   = 1'b0;
          end else begin
            w_addr_nxt  = w_fetch_tgt;
          end
        end else begin
          // Request must stay stable: remember the redirect until the ack
          if (exc) begin
            w_pend_valid_nxt  = 1'b1;
            w_pend_exc_nxt    = 1'b1;
            w_pend_target_nxt = EXC_VECTOR;
          end else if (redirect_valid && !r_pend_exc) begin
            w_pend_valid_nxt  = 1'b1;
            w_pend_target_nxt = redirect_target;
          end
        end
      end

      S_HALT: begin
        w_req_nxt = 1'b0;
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  // State, PC, handshake and delivery registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_req         <= 1'b0;
      r_addr        <= RESET_PC;
      r_if_valid    <= 1'b0;
      r_if_pc       <= 32'd0;
      r_if_pc_plus1 <= 32'd0;
      r_pend_valid  <= 1'b0;
      r_pend_exc    <= 1'b0;
      r_pend_target <= 32'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_req         <= w_req_nxt;
      r_addr        <= w_addr_nxt;
      r_if_valid    <= w_if_valid_nxt;
      r_if_pc       <= w_if_pc_nxt;
      r_if_pc_plus1 <= w_if_pc_plus1_nxt;
      r_pend_valid  <= w_pend_valid_nxt;
      r_pend_exc    <= w_pend_exc_nxt;
      r_pend_target <= w_pend_target_nxt;
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign if_valid    = r_if_valid;
  assign if_pc       = r_if_pc;
  assign if_pc_plus1 = r_if_pc_plus1;
  assign halted      = (r_state == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_sequencer
// Brief    : Self-checking bench for pc_fetch_sequencer: directed scenarios
//            followed by randomized traffic against a reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pc_fetch_sequencer;

  localparam logic [31:0] c_RST = 32'h0000_0000;
  localparam logic [31:0] c_EXC = 32'h0000_0020;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_ack = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        exc = 1'b0;
  logic        halt = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus1;
  logic        halted;

  pc_fetch_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .exc             (exc),
    .halt            (halt),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_pc_plus1     (if_pc_plus1),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: what the outside world should see next cycle
  bit          m_req, m_valid, m_halt, m_waiting, m_stalled;
  logic [31:0] m_addr, m_if_pc, m_plus1, m_resume;
  // Redirect slot: rank 0 empty, 1 branch, 2 exception; higher rank is sticky
  int          slot_rank;
  logic [31:0] slot_tgt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_req = 0; m_valid = 0; m_halt = 0; m_waiting = 1; m_stalled = 0;
    m_addr = c_RST; m_if_pc = 0; m_plus1 = 0; m_resume = c_RST;
    slot_rank = 0; slot_tgt = 0;
  endtask

  task automatic slot_offer(input bit rv, input logic [31:0] rt, input bit e);
    if (rv && slot_rank <= 1) begin slot_rank = 1; slot_tgt = rt; end
    if (e) begin slot_rank = 2; slot_tgt = c_EXC; end
  endtask

  task automatic model_step(input bit a, input bit st, input bit rv,
                            input logic [31:0] rt, input bit e, input bit h);
    logic [31:0] nxt;
    m_valid = 0;
    if (m_halt) begin
      m_req = 0;
    end else if (m_waiting || m_stalled) begin
      if (e) m_resume = c_EXC;
      else if (rv) m_resume = rt;
      if (m_waiting || !st) begin
        m_waiting = 0; m_stalled = 0; m_req = 1; m_addr = m_resume;
      end
    end else if (a) begin
      slot_offer(rv, rt, e);
      m_valid  = (slot_rank == 0);
      m_if_pc  = m_addr;
      m_plus1  = m_addr + 32'd1;
      nxt      = (slot_rank != 0) ? slot_tgt : m_addr + 32'd1;
      slot_rank = 0;
      m_resume = nxt;
      if (h && !e) begin m_halt = 1; m_req = 0; end
      else if (st) begin m_stalled = 1; m_req = 0; end
      else m_addr = nxt;
    end else begin
      slot_offer(rv, rt, e);
    end
  endtask

  // Compare outputs for the current cycle, then drive one cycle of stimulus
  task automatic step(input bit a, input bit st, input bit rv,
                      input logic [31:0] rt, input bit e, input bit h);
    chk("imem_req", {31'd0, imem_req}, {31'd0, m_req});
    if (m_req) chk("imem_addr", imem_addr, m_addr);
    chk("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
    if (m_valid) begin
      chk("if_pc", if_pc, m_if_pc);
      chk("if_pc_plus1", if_pc_plus1, m_plus1);
    end
    chk("halted", {31'd0, halted}, {31'd0, m_halt});
    imem_ack = a; stall = st; redirect_valid = rv; redirect_target = rt;
    exc = e; halt = h;
    model_step(a, st, rv, rt, e, h);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    imem_ack = 0; stall = 0; redirect_valid = 0; redirect_target = 0;
    exc = 0; halt = 0;
    reset = 1;
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, c_RST);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_plus1", if_pc_plus1, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    model_reset();
  endtask

  initial begin
    bit a, st, rv, e, h;
    logic [31:0] rt;
    model_reset();

    // Sequential fetch with an ack every cycle
    do_reset();
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0);
    chk("seq_addr5", imem_addr, 32'd5);

    // Ack withheld three cycles at 5, redirect in the second wait cycle
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h40, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("hold_addr5", imem_addr, 32'd5);
    step(1, 0, 0, 0, 0, 0);
    chk("squash5", {31'd0, if_valid}, 32'd0);
    chk("redir_addr", imem_addr, 32'h40);

    // Redirect and exception together with the ack
    step(1, 0, 1, 32'h80, 1, 0);
    chk("exc_addr", imem_addr, c_EXC);
    chk("exc_squash", {31'd0, if_valid}, 32'd0);

    // Stall at ack of address 7 for four cycles
    step(1, 0, 1, 32'd7, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("stall_deliver", if_pc, 32'd7);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("unstall_addr", imem_addr, 32'd8);

    // Wrap of the PC at the top of the address space
    step(1, 0, 1, 32'hFFFF_FFFF, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("wrap_plus1", if_pc_plus1, 32'd0);
    chk("wrap_addr", imem_addr, 32'd0);

    // Halt at ack of address 3, then exception is ignored
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 1, 32'h99, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_noreq", {31'd0, imem_req}, 32'd0);
    do_reset();
    step(0, 0, 0, 0, 0, 0);
    chk("resume_addr", imem_addr, c_RST);
    step(1, 0, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) < 3) begin
        do_reset();
      end else begin
        a  = m_req && ($urandom_range(0, 99) < 60);
        st = ($urandom_range(0, 99) < 15);
        rv = ($urandom_range(0, 99) < 8);
        rt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : {16'd0, 16'($urandom)};
        e  = ($urandom_range(0, 99) < 4);
        h  = a && ($urandom_range(0, 99) < 1);
        step(a, st, rv, rt, e, h);
      end
    end
    step(0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
